lcd_hd44780_responder: RTL
==========================

Name: lcd_hd44780_responder

Overview:
- Synthesizable model of the HD44780 character-LCD controller. It is the responder on the 8-bit LCD_DATA/RS/RW/EN bus that our LCD display/control path drives.
- Decodes commands, holds 80-byte DDRAM, address counter (AC) and display flags, models the busy flag, and answers read cycles.
- Used as an on-chip display mirror and as the DUT-side end for bus-level regression of the LCD writer.

Parameters:
- BUSY_CYCLES, 2000, clk cycles busy after any non-clear command or data write (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, clk cycles busy after Clear Display (1.64 ms); must be >= 80.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- LCD_DATA  in  8  bus data from initiator
- LCD_RS  in  1  0 = instruction, 1 = data
- LCD_RW  in  1  0 = write, 1 = read
- LCD_EN  in  1  enable strobe (async to clk)
- lcd_dout  out  8  read-back data
- lcd_dout_oe  out  1  drive enable for lcd_dout
- rd_addr  in  7  mirror read address, DDRAM address code
- rd_data  out  8  DDRAM[rd_addr], registered
- busy  out  1  busy flag (BF)
- ac  out  7  address counter
- display_on, cursor_on, blink_on  out  1 each  display-control flags
- cmd_strobe  out  1  one-cycle pulse per accepted instruction write
- data_strobe  out  1  one-cycle pulse per accepted data write
- err_busy_wr  out  1  sticky: a write arrived while busy

Behaviour:
- Input sync: LCD_EN, LCD_RS, LCD_RW, LCD_DATA each pass through 2 flops.
- A transaction commits on the synced EN falling edge (en_s2=0, en_s3=1). Latency from the raw EN fall is 3 clk.
- EN high must last >= 3 clk. Shorter pulses may be missed; this is legal and untested.
- Reset values: AC=0, I/D=1, busy=0, display_on=0, cursor_on=0, blink_on=0, strobes=0, err_busy_wr=0, lcd_dout=0, lcd_dout_oe=0, rd_data=0, DDRAM=0x20.
- DDRAM addressing: valid codes are 0x00-0x27 and 0x40-0x67.
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
  - Set DDRAM address with an invalid code (0x28-0x3F, 0x68-0x7F) clamps AC to 0x00.
- Instruction decode (RS=0, RW=0), highest set bit wins:
  - 1xxxxxxx: AC = D[6:0] (clamped).
  - 01xxxxxx (CGRAM): accepted, no effect.
  - 001xxxxx (function set): accepted, no state change.
  - 0001xxxx (shift): accepted, no effect.
  - 00001DCB: display_on=D, cursor_on=C, blink_on=B.
  - 000001IS: I/D=I; S is ignored.
  - 0000001x: AC=0.
  - 00000001: clear.
  - 0x00: ignored, no strobe.
- Data write (RS=1, RW=0): DDRAM[AC] = data, then AC advances per I/D. data_strobe pulses.
- Busy state machine: IDLE -> BUSY (counter loaded) -> IDLE.
  - Every accepted write loads the counter with BUSY_CYCLES-1; busy=1 until it reaches 0.
  - Clear enters state CLEARING: writes 0x20 to DDRAM codes in order, one per clk (80 cycles), sets AC=0 and I/D=1, then holds BUSY until CLEAR_CYCLES total have elapsed.
- Write while busy=1: ignored entirely. No strobe, no state change, err_busy_wr=1 until reset.
- Read instruction (RS=0, RW=1): while synced EN=1, lcd_dout={busy,ac} and lcd_dout_oe=1. No state change on the fall.
- Read data (RS=1, RW=1): lcd_dout=DDRAM[AC] while EN=1. On the fall, AC advances if not busy. Reads are never blocked and never flag errors.
- lcd_dout_oe drops the cycle after the synced EN falls.
- rd_data is registered: 1 clk latency from rd_addr. Invalid codes return 0x20.
- Mirror reads collide with data writes: the write wins the memory port that cycle and rd_data holds its old value for that cycle.
- rst asserted mid-clear or mid-busy aborts immediately to reset values, including a full DDRAM re-fill to 0x20 (implemented as a reset-time fill sequence). busy=1 during the fill; the fill runs after rst deasserts.

Test Plan:
- Reset release: busy=1 for 80 clk (fill), then 0; rd_data for all 80 codes = 0x20; ac=0; display_on=0.
- Writer init sequence 0x38, 0x0C, 0x01, 0x06, 0x80 with gaps > CLEAR_CYCLES:
  - display_on=1, cursor_on=0, blink_on=0, ac=0x00;
  - 5 cmd_strobe pulses; err_busy_wr=0.
- Data "Welcome" from AC=0x00, then cmd 0xC0, then "Altera":
  - DDRAM[0x00..0x06]="Welcome", DDRAM[0x40..0x45]="Altera";
  - final ac=0x46.
- Wrap: cmd 0xA7 then data 0x41 -> DDRAM[0x27]=0x41, ac=0x40. Then cmd 0x04, cmd 0x80, data 0x42 -> DDRAM[0x00]=0x42, ac=0x67.
- Write during busy: data 0x55 issued 100 clk after a prior write (BUSY_CYCLES=2000) -> DDRAM unchanged, no data_strobe, err_busy_wr=1. Read instruction during busy returns lcd_dout[7]=1 and lcd_dout[6:0]=ac.
- Reset mid-clear: issue 0x01, assert rst after 40 clk -> all outputs take reset values. After release, the fill completes and all DDRAM = 0x20.

Source files
------------

// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_hd44780_responder
//  Purpose  : HD44780 character-LCD controller model answering the 8-bit
//             LCD bus: command decode, 80-byte DDRAM, AC, busy flag, reads.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    output logic [7:0] lcd_dout,
    output logic       lcd_dout_oe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       cmd_strobe,
    output logic       data_strobe,
    output logic       err_busy_wr
);

    localparam int c_CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [1:0] c_S_FILL  = 2'd0;
    localparam logic [1:0] c_S_IDLE  = 2'd1;
    localparam logic [1:0] c_S_BUSY  = 2'd2;
    localparam logic [1:0] c_S_CLEAR = 2'd3;

    localparam logic [6:0] c_LAST_IDX = 7'd79;
    localparam logic [7:0] c_BLANK    = 8'h20;

    // DDRAM codes 0x00-0x27 map to 0-39, 0x40-0x67 map to 40-79
    function automatic logic [6:0] codeToIdx(input logic [6:0] code);
        return code[6] ? ({1'b0, code[5:0]} + 7'd40) : {1'b0, code[5:0]};
    endfunction

    function automatic logic codeValid(input logic [6:0] code);
        return code[5:0] < 6'd40;
    endfunction

    logic       r_enS1, r_enS2, r_enS3;
    logic       r_rsS1, r_rsS2, r_rwS1, r_rwS2;
    logic [7:0] r_dataS1, r_dataS2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [6:0]         r_fillIdx;
    logic [6:0]         r_ac;
    logic               r_incr;
    logic               r_busy;
    logic               r_dispOn, r_cursOn, r_blinkOn;
    logic               r_cmdStrobe, r_dataStrobe, r_errBusyWr;
    logic [7:0]         r_lcdDout;
    logic               r_lcdDoutOe;
    logic [7:0]         r_rdData;

    logic [7:0] r_ddram [0:79];

    logic       w_fall, w_idle, w_wrCommit, w_acceptData, w_acceptCmd;
    logic       w_filling;
    logic [6:0] w_acIdx, w_acNext, w_rdIdx;
    logic       w_memWe;
    logic [6:0] w_memIdx;
    logic [7:0] w_memWdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enS1   <= 1'b0;
            r_enS2   <= 1'b0;
            r_enS3   <= 1'b0;
            r_rsS1   <= 1'b0;
            r_rsS2   <= 1'b0;
            r_rwS1   <= 1'b0;
            r_rwS2   <= 1'b0;
            r_dataS1 <= 8'h00;
            r_dataS2 <= 8'h00;
        end else begin
            r_enS1   <= LCD_EN;
            r_enS2   <= r_enS1;
            r_enS3   <= r_enS2;
            r_rsS1   <= LCD_RS;
            r_rsS2   <= r_rsS1;
            r_rwS1   <= LCD_RW;
            r_rwS2   <= r_rwS1;
            r_dataS1 <= LCD_DATA;
            r_dataS2 <= r_dataS1;
        end
    end

    assign w_fall       = !r_enS2 && r_enS3;
    assign w_idle       = (r_state == c_S_IDLE);
    assign w_wrCommit   = w_fall && !r_rwS2;
    assign w_acceptData = w_wrCommit && r_rsS2 && w_idle;
    assign w_acceptCmd  = w_wrCommit && !r_rsS2 && w_idle && (r_dataS2 != 8'h00);
    assign w_filling    = (r_state == c_S_FILL) || (r_state == c_S_CLEAR);
    assign w_acIdx      = codeToIdx(r_ac);
    assign w_rdIdx      = codeToIdx(rd_addr);

    always_comb begin
        w_acNext = r_ac;
        if (r_incr) begin
            if (r_ac == 7'h27)      w_acNext = 7'h40;
            else if (r_ac == 7'h67) w_acNext = 7'h00;
            else                    w_acNext = r_ac + 7'd1;
        end else begin
            if (r_ac == 7'h00)      w_acNext = 7'h67;
            else if (r_ac == 7'h40) w_acNext = 7'h27;
            else                    w_acNext = r_ac - 7'd1;
        end
    end

    // Single write port shared by the blanking sweep and data writes
    assign w_memWe    = w_filling || w_acceptData;
    assign w_memIdx   = w_filling ? r_fillIdx : w_acIdx;
    assign w_memWdata = w_filling ? c_BLANK : r_dataS2;

    always_ff @(posedge clk) begin
        if (w_memWe) r_ddram[w_memIdx] <= w_memWdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_S_FILL;
            r_cnt        <= '0;
            r_fillIdx    <= 7'd0;
            r_ac         <= 7'd0;
            r_incr       <= 1'b1;
            r_busy       <= 1'b0;
            r_dispOn     <= 1'b0;
            r_cursOn     <= 1'b0;
            r_blinkOn    <= 1'b0;
            r_cmdStrobe  <= 1'b0;
            r_dataStrobe <= 1'b0;
            r_errBusyWr  <= 1'b0;
        end else begin
            r_cmdStrobe  <= 1'b0;
            r_dataStrobe <= 1'b0;
            if (w_wrCommit && !w_idle) r_errBusyWr <= 1'b1;

            case (r_state)
                c_S_FILL: begin
                    r_busy <= 1'b1;
                    if (r_fillIdx == c_LAST_IDX) begin
                        r_fillIdx <= 7'd0;
                        r_state   <= c_S_IDLE;
                    end else begin
                        r_fillIdx <= r_fillIdx + 7'd1;
                    end
                end

                c_S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_acceptData) begin
                        r_ac         <= w_acNext;
                        r_dataStrobe <= 1'b1;
                        r_state      <= c_S_BUSY;
                        r_cnt        <= c_CNT_W'(BUSY_CYCLES - 1);
                        r_busy       <= 1'b1;
                    end else if (w_acceptCmd) begin
                        r_cmdStrobe <= 1'b1;
                        r_state     <= c_S_BUSY;
                        r_cnt       <= c_CNT_W'(BUSY_CYCLES - 1);
                        r_busy      <= 1'b1;
                        casez (r_dataS2)
                            8'b1???????: r_ac <= codeValid(r_dataS2[6:0]) ? r_dataS2[6:0] : 7'h00;
                            8'b00001???: begin
                                r_dispOn  <= r_dataS2[2];
                                r_cursOn  <= r_dataS2[1];
                                r_blinkOn <= r_dataS2[0];
                            end
                            8'b000001??: r_incr <= r_dataS2[1];
                            8'b0000001?: r_ac <= 7'h00;
                            8'b00000001: begin
                                r_state   <= c_S_CLEAR;
                                r_cnt     <= c_CNT_W'(CLEAR_CYCLES - 1);
                                r_fillIdx <= 7'd0;
                            end
                            default: ;
                        endcase
                    end else if (w_fall && r_rwS2 && r_rsS2) begin
                        r_ac <= w_acNext;
                    end
                end

                c_S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    r_busy <= 1'b1;
                    if (r_fillIdx == c_LAST_IDX) begin
                        r_fillIdx <= 7'd0;
                        r_ac      <= 7'h00;
                        r_incr    <= 1'b1;
                        if (r_cnt == '0) begin
                            r_state <= c_S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= c_S_BUSY;
                            r_cnt   <= r_cnt - 1'b1;
                        end
                    end else begin
                        r_fillIdx <= r_fillIdx + 7'd1;
                        r_cnt     <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Mirror port yields to any DDRAM write in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData    <= 8'h00;
            r_lcdDout   <= 8'h00;
            r_lcdDoutOe <= 1'b0;
        end else begin
            if (!w_memWe) r_rdData <= codeValid(rd_addr) ? r_ddram[w_rdIdx] : c_BLANK;
            if (r_enS2 && r_rwS2) begin
                r_lcdDoutOe <= 1'b1;
                r_lcdDout   <= r_rsS2 ? r_ddram[w_acIdx] : {r_busy, r_ac};
            end else begin
                r_lcdDoutOe <= 1'b0;
            end
        end
    end

    assign lcd_dout    = r_lcdDout;
    assign lcd_dout_oe = r_lcdDoutOe;
    assign rd_data     = r_rdData;
    assign busy        = r_busy;
    assign ac          = r_ac;
    assign display_on  = r_dispOn;
    assign cursor_on   = r_cursOn;
    assign blink_on    = r_blinkOn;
    assign cmd_strobe  = r_cmdStrobe;
    assign data_strobe = r_dataStrobe;
    assign err_busy_wr = r_errBusyWr;

endmodule
`default_nettype wire
